// File: rtl/board_line_fetch.sv
// Board line fetcher: prefetches one board row word per scan line
// during hblank and swaps it into currLine at end of line.
module board_line_fetch #(
  parameter logic [9:0] BOARD_BASE = 10'd0,
  parameter int ROW_HEIGHT = 24,
  parameter int NUM_ROWS   = 20,
  parameter int H_VISIBLE  = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  mem_addr,
  output logic        mem_ren,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] currLine,
  output logic        fetch_err
);

  localparam int RW  = $clog2(NUM_ROWS);
  localparam int SW  = $clog2(ROW_HEIGHT);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int VIS = ROW_HEIGHT * NUM_ROWS;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic          trig;
  logic          swap;
  logic          vis;
  logic [9:0]    nv;
  logic [RW-1:0] row_idx;
  logic [RW-1:0] row_nx;
  logic [SW-1:0] sub_line;
  logic [SW-1:0] sub_nx;
  logic [TW-1:0] tcnt;
  logic [15:0]   shadow;

  assign trig = (hcount == 10'(H_VISIBLE));
  assign swap = (hcount == 10'(H_TOTAL - 1));
  assign nv   = (vcount == 10'(V_TOTAL - 1)) ? 10'd0
                                             : vcount + 10'd1;
  assign vis  = (nv < 10'(VIS));

  // Row/sub-line counters replace a divide of nv by ROW_HEIGHT.
  always_comb begin
    row_nx = row_idx;
    sub_nx = sub_line + SW'(1);
    if (nv == 10'd0) begin
      row_nx = '0;
      sub_nx = '0;
    end else if (sub_line == SW'(ROW_HEIGHT - 1)) begin
      sub_nx = '0;
      row_nx = (row_idx == RW'(NUM_ROWS - 1)) ? '0
                                              : row_idx + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      currLine  <= '0;
      shadow    <= '0;
      fetch_err <= 1'b0;
      mem_ren   <= 1'b0;
      mem_addr  <= BOARD_BASE;
      row_idx   <= '0;
      sub_line  <= '0;
      tcnt      <= '0;
    end else begin
      mem_ren <= 1'b0;
      if (trig) begin
        row_idx  <= row_nx;
        sub_line <= sub_nx;
      end
      if (swap) begin
        state <= IDLE;
        if (state == REQ || state == WAIT) begin
          currLine  <= '0;
          fetch_err <= 1'b1;
        end else begin
          currLine <= shadow;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (trig) begin
              if (vis) begin
                state    <= REQ;
                mem_ren  <= 1'b1;
                mem_addr <= BOARD_BASE + 10'(row_nx);
              end else begin
                shadow <= '0;
              end
            end
          end
          REQ: begin
            state <= WAIT;
            tcnt  <= '0;
          end
          WAIT: begin
            if (mem_rvalid) begin
              shadow <= {6'b0, mem_rdata[9:0]};
              state  <= DONE;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
              shadow    <= '0;
              fetch_err <= 1'b1;
              state     <= DONE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          DONE: begin
            state <= DONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_line_fetch.sv
// Testbench for board_line_fetch: compressed scan lines drive the
// trigger/swap cycles; a one-deep memory model answers reads.
module tb_board_line_fetch;

  localparam logic [9:0] BASE = 10'h100;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [9:0]  mem_addr;
  logic        mem_ren;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] currLine;
  logic        fetch_err;

  board_line_fetch #(
    .BOARD_BASE(BASE),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hcount(hcount),
    .vcount(vcount),
    .mem_addr(mem_addr),
    .mem_ren(mem_ren),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .currLine(currLine),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  v;
    bit          fix;
    logic [15:0] data;
    int          lat;
    logic [15:0] exp_line;
    logic [9:0]  exp_addr;
    bit          exp_ren;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  int          cd = 0;
  logic [15:0] pend = '0;
  bit          withhold = 1'b0;
  bit          fix_en = 1'b0;
  logic [15:0] fix_val = '0;
  int          lat = 2;

  function automatic logic [15:0] word(input int r);
    return 16'd1 << (r % 10);
  endfunction

  function automatic logic [15:0] expl(input int nv);
    return (nv < 480) ? (word(nv / 24) & 16'h03FF) : 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s v=%0d: got %0h expected %0h",
               name, vcount, act, exp);
    end
  endtask

  // One clock; the memory model answers lat cycles after mem_ren.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend;
      end
    end
    if (mem_ren === 1'b1 && !withhold) begin
      pend = fix_en ? fix_val : word(int'(mem_addr - BASE));
      cd   = lat - 1;
    end
  endtask

  task automatic run_line(input logic [9:0] v, input int len,
                          input bit late, input logic [15:0] el,
                          input logic [9:0] ea, input bit er);
    int rens;
    rens = 0;
    vcount = v;
    hcount = 10'd640;
    exp_q.push_back(el);
    tick();
    if (er) begin
      chk("ren_after_trigger", 32'(mem_ren), 32'd1);
      chk("mem_addr", 32'(mem_addr), 32'(ea));
    end
    for (int i = 1; i < len; i++) begin
      if (mem_ren) rens++;
      hcount = 10'(640 + i);
      tick();
    end
    if (mem_ren) rens++;
    hcount = 10'd799;
    if (late) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h0155;
    end
    tick();
    hcount = 10'd0;
    chk("ren_count", 32'(rens), er ? 32'd1 : 32'd0);
    chk("currLine", 32'(currLine), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int v;
    int nv;
    reset      = 1'b1;
    hcount     = 10'd0;
    vcount     = 10'd0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;

    tbl.push_back('{10'd524, 1'b0, 16'h0000, 2, 16'h0001,
                    BASE, 1'b1});
    for (int i = 0; i < 23; i++)
      tbl.push_back('{10'(i), 1'b0, 16'h0000, 2 + (i % 4),
                      expl(i + 1), 10'(BASE + (i + 1) / 24), 1'b1});
    tbl.push_back('{10'd23, 1'b1, 16'hFFFF, 3, 16'h03FF,
                    BASE + 10'd1, 1'b1});
    tbl.push_back('{10'd24, 1'b1, 16'h5A5A, 2, 16'h025A,
                    BASE + 10'd1, 1'b1});
    tbl.push_back('{10'd25, 1'b1, 16'h0155, 5, 16'h0155,
                    BASE + 10'd1, 1'b1});

    tick();
    tick();
    chk("rst_currLine", 32'(currLine), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    reset = 1'b0;
    tick();

    foreach (tbl[k]) begin
      fix_en  = tbl[k].fix;
      fix_val = tbl[k].data;
      lat     = tbl[k].lat;
      run_line(tbl[k].v, 26, 1'b0, tbl[k].exp_line,
               tbl[k].exp_addr, tbl[k].exp_ren);
    end
    chk("err_after_table", 32'(fetch_err), 32'd0);

    // Full frame with a row-dependent pattern.
    fix_en = 1'b0;
    lat    = 3;
    for (int k = 0; k < 525; k++) begin
      v  = (k == 0) ? 524 : k - 1;
      nv = (v == 524) ? 0 : v + 1;
      run_line(10'(v), 26, 1'b0, expl(nv), 10'(BASE + nv / 24),
               nv < 480);
    end
    chk("err_after_frame", 32'(fetch_err), 32'd0);

    // Withheld rvalid: timeout sets the sticky error.
    withhold = 1'b1;
    vcount = 10'd524;
    hcount = 10'd640;
    tick();
    chk("tmo_ren", 32'(mem_ren), 32'd1);
    chk("tmo_addr", 32'(mem_addr), 32'(BASE));
    for (int i = 1; i <= TMO; i++) begin
      hcount = 10'(640 + i);
      tick();
    end
    chk("tmo_err_early", 32'(fetch_err), 32'd0);
    hcount = 10'(641 + TMO);
    tick();
    chk("tmo_err_set", 32'(fetch_err), 32'd1);
    for (int i = TMO + 2; i < 26; i++) begin
      hcount = 10'(640 + i);
      tick();
    end
    hcount = 10'd799;
    tick();
    hcount = 10'd0;
    chk("tmo_currLine", 32'(currLine), 32'd0);

    withhold = 1'b0;
    run_line(10'd0, 26, 1'b0, 16'h0001, BASE, 1'b1);
    chk("err_sticky", 32'(fetch_err), 32'd1);

    // rvalid landing on the swap cycle counts as late.
    withhold = 1'b1;
    run_line(10'd1, 10, 1'b1, 16'h0000, BASE, 1'b1);
    chk("late_err", 32'(fetch_err), 32'd1);

    // Reset while waiting; the stale response must be dropped.
    withhold = 1'b0;
    fix_en   = 1'b1;
    fix_val  = 16'h0155;
    lat      = 5;
    vcount   = 10'd524;
    hcount   = 10'd640;
    tick();
    chk("rw_ren", 32'(mem_ren), 32'd1);
    hcount = 10'd641;
    tick();
    hcount = 10'd642;
    tick();
    reset = 1'b1;
    hcount = 10'd643;
    tick();
    reset = 1'b0;
    chk("rw_err_clr", 32'(fetch_err), 32'd0);
    chk("rw_addr", 32'(mem_addr), 32'(BASE));
    for (int i = 4; i < 12; i++) begin
      hcount = 10'(640 + i);
      tick();
    end
    chk("rw_currLine_mid", 32'(currLine), 32'd0);
    chk("rw_ren_idle", 32'(mem_ren), 32'd0);
    hcount = 10'd799;
    tick();
    hcount = 10'd0;
    chk("rw_currLine_swap", 32'(currLine), 32'd0);
    chk("rw_err_final", 32'(fetch_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
